// File: rtl/axi_packet_reframer_pkg.sv
// Shared constants and FSM state type for the packet reframer.
package axi_packet_reframer_pkg;

  localparam int unsigned SR_SPP_DEFAULT   = 129;
  localparam int unsigned SPP_BITS_DEFAULT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } state_e;

endpackage

// File: rtl/axi_reg_stage.sv
// Single-entry registered AXI-Stream stage: 1-cycle latency, full throughput, holds under stall.
module axi_reg_stage #(
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [Width-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (in_valid_i && in_ready_o) begin
      data_d  = in_data_i;
      valid_d = 1'b1;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/axi_packet_reframer.sv
// Re-frames a sample stream into packets of SPP beats (SPP=0: pass-through).
// Optional completed-packet counter enabled by AXI_PACKET_REFRAMER_PKT_CNT_EN.
module axi_packet_reframer
  import axi_packet_reframer_pkg::*;
#(
  parameter int unsigned SR_SPP      = SR_SPP_DEFAULT,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SPP_BITS    = SPP_BITS_DEFAULT,
  parameter bit          HONOR_ILAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
`ifdef AXI_PACKET_REFRAMER_PKT_CNT_EN
  ,
  output logic [31:0]      pkt_count
`endif
);

  localparam logic [7:0]          SppAddr = 8'(SR_SPP);
  localparam logic [SPP_BITS-1:0] SppOne  = SPP_BITS'(1);

  state_e              state_q, state_d;
  logic [SPP_BITS-1:0] spp_q, spp_d;
  logic [SPP_BITS-1:0] spp_active_q, spp_active_d;
  logic [SPP_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [SPP_BITS-1:0] cur_spp, cur_cnt;
  logic                accept, out_last;

  assign accept = i_tvalid && i_tready;

  always_comb begin
    spp_d        = spp_q;
    state_d      = state_q;
    spp_active_d = spp_active_q;
    beat_cnt_d   = beat_cnt_q;

    if (set_stb && set_addr == SppAddr) begin
      spp_d = set_data[SPP_BITS-1:0];
    end

    // A beat accepted in IDLE opens a packet with the SPP registered before this edge.
    cur_spp = (state_q == IDLE) ? spp_q : spp_active_q;
    cur_cnt = (state_q == IDLE) ? '0 : beat_cnt_q;

    if (cur_spp == '0) begin
      out_last = i_tlast;
    end else begin
      out_last = (cur_cnt == cur_spp - SppOne) || (HONOR_ILAST && i_tlast);
    end

    if (accept) begin
      spp_active_d = cur_spp;
      if (out_last) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
      end else begin
        state_d    = MID;
        beat_cnt_d = (cur_spp == '0) ? '0 : cur_cnt + SppOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      spp_q        <= '0;
      spp_active_q <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      spp_q        <= spp_d;
      spp_active_q <= spp_active_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  axi_reg_stage #(
    .Width(WIDTH + 1)
  ) u_out_stage (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data_i  ({i_tdata, out_last}),
    .in_valid_i (i_tvalid),
    .in_ready_o (i_tready),
    .out_data_o ({o_tdata, o_tlast}),
    .out_valid_o(o_tvalid),
    .out_ready_i(o_tready)
  );

`ifdef AXI_PACKET_REFRAMER_PKT_CNT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (o_tvalid && o_tready && o_tlast) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: doc/axi_packet_reframer.md
Name: axi_packet_reframer

Overview:
- Re-frames a 32-bit sample stream into packets of a programmable length (samples-per-packet, SPP) before it reaches the AXI wrapper's s_axis_data input.
- Sits directly downstream of the compute-engine sample FIFO, between the FIFO output and s_axis_data inside an RFNoC block.
- SPP is written over the noc_shell settings bus.
- SPP=0 selects pass-through, where input tlast is forwarded unchanged.

Parameters:
- SR_SPP, 129, settings-bus address of the SPP register (the slot after SR_NEXT_DST=128).
- WIDTH, 32, data width of i_tdata/o_tdata.
- SPP_BITS, 16, width of the SPP register and beat counter.
- HONOR_ILAST, 1, 1 = an input tlast also ends the current output packet early; 0 = input tlast is ignored when SPP≠0.

Ports:
- clk  in  1  compute-engine clock.
- reset_n  in  1  reset.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data; SPP is taken from bits [SPP_BITS-1:0].
- i_tdata  in  WIDTH  input samples.
- i_tlast  in  1  input end-of-packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output samples.
- o_tlast  out  1  output end-of-packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- pkt_count  out  32  count of completed output packets; present only with the optional feature.
- Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (reset_n low, asynchronous):
  - o_tvalid=0, o_tlast=0, o_tdata=0.
  - spp_reg=0, spp_active=0, beat_cnt=0, state=IDLE, pkt_count=0.
  - Takes effect immediately, including mid-packet.
  - After release, the first accepted beat starts a fresh packet.
- Settings: set_stb && set_addr==SR_SPP loads spp_reg on the next edge. Other addresses are ignored.
- Handshake:
  - One registered output stage.
  - i_tready = !o_tvalid || o_tready.
  - Beat accepted when i_tvalid && i_tready.
  - Latency is exactly 1 cycle.
  - Throughput is 1 beat/cycle under continuous o_tready.
  - o_tdata, o_tlast and o_tvalid hold stable while o_tvalid && !o_tready.
- State machine, on accepted beats only:
  - IDLE: no packet open. On accept, set spp_active = spp_reg (the value registered before this edge; a same-cycle write applies to the next packet).
    - If the beat is also last, stay in IDLE with beat_cnt=0.
    - Otherwise go to MID with beat_cnt=1.
  - MID: packet open. On accept, beat_cnt increments.
    - On a last beat, go to IDLE with beat_cnt=0.
- Last-beat rule, with spp_active as defined above:
  - spp_active==0: out_last = i_tlast.
  - spp_active≠0: out_last = (beat_cnt == spp_active-1) || (HONOR_ILAST && i_tlast).
  - SPP=1 marks every beat last.
- SPP changes mid-packet never alter the open packet; they apply at the next IDLE accept.
- Width/wrap rules:
  - beat_cnt is SPP_BITS wide and never exceeds spp_active-1 when spp_active≠0.
  - In pass-through, beat_cnt is held at 0.
  - Max SPP is 2^SPP_BITS-1.
- Back-pressure: o_tready low for any number of cycles loses and duplicates no beats.

Optional Feature:
- Macro: AXI_PACKET_REFRAMER_PKT_CNT_EN.
- With the macro defined:
  - pkt_count port exists.
  - It increments by 1 on each output handshake (o_tvalid && o_tready && o_tlast).
  - It wraps 0xFFFF_FFFF→0 and is cleared by reset.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package axi_packet_reframer_pkg holds:
  - SR_SPP default address constant.
  - SPP_BITS default.
  - State typedef {IDLE, MID}.
- One natural sub-module, axi_reg_stage: the single-entry registered output stage (data+last, valid/ready).
- Counter and FSM stay in the top module.

Test Plan:
- Framing: SPP=4, 10 beats 0..9 streamed, input tlast only on beat 9, o_tready=1 → output tlast on beats 3, 7, 9 (9 is early termination with HONOR_ILAST=1); first output is 1 cycle after first accept.
- Pass-through: SPP=0, input packets of 3 and 5 beats → output tlast only on input tlast positions (beats 2 and 7); data unchanged.
- Back-pressure: SPP=2, 8 beats, o_tready toggled with a 1-of-3 pattern → all 8 beats out in order; tlast on 1, 3, 5, 7; o_tdata stable while stalled.
- Mid-packet reconfiguration: SPP=5, write SPP=2 after beat 1 accepted → the first packet still ends at beat 4; subsequent packets end every 2 beats (6, 8…).
- Reset mid-packet: SPP=4, assert reset_n low after beat 2 → o_tvalid drops asynchronously; after release with SPP rewritten to 4, the next 4 beats form one packet with tlast on the 4th.
- AXI_PACKET_REFRAMER_PKT_CNT_EN: SPP=1, 5 beats → pkt_count reads 5; preload condition 0xFFFF_FFFF plus one packet → 0.
